// File: rtl/nco_ctrl_pkg.sv
// Shared types and defaults for the NCO sweep controller.
// Holds the FSM state encoding, the NCO word width and the settle latency.
package nco_ctrl_pkg;

    localparam int NCO_W_DEF  = 13;
    localparam int SETTLE_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_DWELL,
        S_EVAL,
        S_TRACK
    } state_t;

endpackage

// File: rtl/nco_sweep_ctrl.sv
// NCO frequency-sweep controller: steps the NCO word, records the correlator peak
// per point, then parks on the strongest word if it clears the lock threshold.
//   in : clk, rst, start, abort, f_min, f_step, n_steps, dwell, phase_offset,
//        lock_thresh, corr_valid, corr_mag
//   out: control_word, phase_control_word, nco_rst, busy, done, locked,
//        best_word, best_mag
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEF,
    parameter int W      = NCO_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] f_min,
    input  logic [W-1:0] f_step,
    input  logic [7:0]   n_steps,
    input  logic [15:0]  dwell,
    input  logic [W-1:0] phase_offset,
    input  logic [15:0]  lock_thresh,
    input  logic         corr_valid,
    input  logic [15:0]  corr_mag,
    output logic [W-1:0] control_word,
    output logic [W-1:0] phase_control_word,
    output logic         nco_rst,
    output logic         busy,
    output logic         done,
    output logic         locked,
    output logic [W-1:0] best_word,
    output logic [15:0]  best_mag
);

    localparam logic [15:0] SETTLE_LD = 16'(SETTLE - 1);

    state_t       state;
    state_t       state_n;
    logic [15:0]  cnt;
    logic [7:0]   step_idx;
    logic [7:0]   last_idx;
    logic [W-1:0] step_q;
    logic [15:0]  dwell_ld;
    logic [15:0]  thresh_q;
    logic [15:0]  peak;
    logic         cnt_zero;
    logic         last_step;
    logic         better;
    logic [W-1:0] best_word_n;
    logic [15:0]  best_mag_n;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n     = state;
        busy        = 1'b0;
        nco_rst     = rst;
        cnt_zero    = (cnt == 16'd0);
        last_step   = (step_idx == last_idx);
        // Strict compare: an equal peak later in the sweep keeps the earlier word.
        better      = (peak > best_mag);
        best_mag_n  = better ? peak : best_mag;
        best_word_n = better ? control_word : best_word;
        unique case (state)
            S_IDLE, S_TRACK: begin
                if (start) state_n = S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                // Counter is still at its load value only in the first settle cycle.
                if (step_idx == 8'd0 && cnt == SETTLE_LD) nco_rst = 1'b1;
                if (cnt_zero) state_n = S_DWELL;
            end
            S_DWELL: begin
                busy = 1'b1;
                if (cnt_zero) state_n = S_EVAL;
            end
            S_EVAL: begin
                busy    = 1'b1;
                state_n = last_step ? S_TRACK : S_SETTLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (abort) state_n = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            control_word       <= '0;
            phase_control_word <= '0;
            best_word          <= '0;
            best_mag           <= '0;
            done               <= 1'b0;
            locked             <= 1'b0;
            cnt                <= '0;
            step_idx           <= '0;
            last_idx           <= '0;
            step_q             <= '0;
            dwell_ld           <= '0;
            thresh_q           <= '0;
            peak               <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                control_word       <= '0;
                phase_control_word <= '0;
                locked             <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE, S_TRACK: begin
                        if (start) begin
                            control_word       <= f_min;
                            phase_control_word <= phase_offset;
                            best_word          <= f_min;
                            best_mag           <= '0;
                            locked             <= 1'b0;
                            step_idx           <= '0;
                            step_q             <= f_step;
                            thresh_q           <= lock_thresh;
                            last_idx  <= (n_steps == 8'd0) ? 8'd0 : n_steps - 8'd1;
                            dwell_ld  <= (dwell == 16'd0) ? 16'd0 : dwell - 16'd1;
                            cnt       <= SETTLE_LD;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt_zero) begin
                            cnt  <= dwell_ld;
                            peak <= '0;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    S_DWELL: begin
                        if (corr_valid && corr_mag > peak) peak <= corr_mag;
                        if (!cnt_zero) cnt <= cnt - 16'd1;
                    end
                    S_EVAL: begin
                        best_mag  <= best_mag_n;
                        best_word <= best_word_n;
                        if (last_step) begin
                            done <= 1'b1;
                            if (best_mag_n >= thresh_q) begin
                                locked       <= 1'b1;
                                control_word <= best_word_n;
                            end else begin
                                control_word <= '0;
                            end
                        end else begin
                            control_word <= control_word + step_q;
                            step_idx     <= step_idx + 8'd1;
                            cnt          <= SETTLE_LD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl.
// Directed sweeps against a per-cycle arithmetic model plus literal checks.
module tb_nco_sweep_ctrl;

    localparam int W  = 13;
    localparam int ST = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] f_min = '0;
    logic [W-1:0] f_step = '0;
    logic [7:0]   n_steps = '0;
    logic [15:0]  dwell = '0;
    logic [W-1:0] phase_offset = '0;
    logic [15:0]  lock_thresh = '0;
    logic         corr_valid = 1'b0;
    logic [15:0]  corr_mag = '0;
    logic [W-1:0] control_word;
    logic [W-1:0] phase_control_word;
    logic         nco_rst;
    logic         busy;
    logic         done;
    logic         locked;
    logic [W-1:0] best_word;
    logic [15:0]  best_mag;

    nco_sweep_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .f_min(f_min), .f_step(f_step), .n_steps(n_steps), .dwell(dwell),
        .phase_offset(phase_offset), .lock_thresh(lock_thresh),
        .corr_valid(corr_valid), .corr_mag(corr_mag),
        .control_word(control_word), .phase_control_word(phase_control_word),
        .nco_rst(nco_rst), .busy(busy), .done(done), .locked(locked),
        .best_word(best_word), .best_mag(best_mag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model of the sweep in progress: mode 0 = idle, 1 = sweep started at m_s.
    int m_mode = 0;
    int m_s, m_fmin, m_fstep, m_ph, m_thr, m_steps, m_per;
    int m_pk [8];
    int h_bw = 0;
    int h_bm = 0;
    int pk [8];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h want 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Best word/peak visible o cycles after the start edge.
    function automatic void model_best(input int o, output int bw, output int bm);
        int k;
        k  = o / m_per;
        if (k > m_steps) k = m_steps;
        bw = m_fmin;
        bm = 0;
        for (int j = 0; j < k; j++) begin
            if (m_pk[j] > bm) begin
                bm = m_pk[j];
                bw = (m_fmin + j * m_fstep) % (1 << W);
            end
        end
    endfunction

    always @(negedge clk) begin
        int o, bw, bm, ecw, epcw, ern, eby, edn, elk;
        if (chk_en) begin
            ern = 0; eby = 0; edn = 0; elk = 0; ecw = 0; epcw = 0;
            bw = h_bw; bm = h_bm;
            if (m_mode == 1) begin
                o    = cyc - m_s;
                epcw = m_ph;
                model_best(o, bw, bm);
                if (o < m_per * m_steps) begin
                    eby = 1;
                    ern = (o == 0) ? 1 : 0;
                    ecw = (m_fmin + (o / m_per) * m_fstep) % (1 << W);
                end else begin
                    edn = (o == m_per * m_steps) ? 1 : 0;
                    elk = (bm >= m_thr) ? 1 : 0;
                    ecw = elk ? bw : 0;
                end
            end
            if (rst) ern = 1;
            check("control_word", 32'(control_word), ecw);
            check("phase_word", 32'(phase_control_word), epcw);
            check("nco_rst", 32'(nco_rst), ern);
            check("busy", 32'(busy), eby);
            check("done", 32'(done), edn);
            check("locked", 32'(locked), elk);
            check("best_word", 32'(best_word), bw);
            check("best_mag", 32'(best_mag), bm);
        end
    end

    // stop_kind 1: abort+start together at offset stop_at; 2: reset there.
    task automatic run_sweep(input int fm, input int fs, input int ph,
                             input int ns, input int dw, input int th,
                             input int stop_at, input int stop_kind,
                             output int done_o);
        int nse, dwe, o, j, pos, d, hb, hm;
        bit hit;
        nse = (ns == 0) ? 1 : ns;
        dwe = (dw == 0) ? 1 : dw;
        f_min = W'(fm); f_step = W'(fs); phase_offset = W'(ph);
        n_steps = 8'(ns); dwell = 16'(dw); lock_thresh = 16'(th);
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        m_fmin  = fm; m_fstep = fs; m_ph = ph; m_thr = th;
        m_steps = nse; m_per = ST + dwe + 1;
        for (int k = 0; k < 8; k++) m_pk[k] = pk[k];
        m_s     = cyc;
        m_mode  = 1;
        f_min = W'($urandom); f_step = W'($urandom); phase_offset = W'($urandom);
        n_steps = 8'($urandom); dwell = 16'($urandom); lock_thresh = 16'($urandom);
        done_o = -1;
        hit    = 1'b0;
        for (int it = 0; it < m_per * nse + 4 && !hit; it++) begin
            o = cyc - m_s;
            if (o == stop_at) begin
                corr_valid = 1'b0;
                model_best(o, hb, hm);
                if (stop_kind == 1) begin abort = 1'b1; start = 1'b1; end
                else rst = 1'b1;
                @(posedge clk); #1;
                abort  = 1'b0;
                start  = 1'b0;
                m_mode = 0;
                h_bw   = (stop_kind == 1) ? hb : 0;
                h_bm   = (stop_kind == 1) ? hm : 0;
                if (stop_kind == 2) begin
                    @(posedge clk); #1;
                    rst = 1'b0;
                end
                hit    = 1'b1;
                done_o = -2;
            end else begin
                j   = o / m_per;
                pos = o % m_per;
                if (pos < ST) begin
                    corr_valid = 1'b1;
                    corr_mag   = 16'hFFFF;
                end else if (pos < ST + dwe) begin
                    d = pos - ST;
                    if ((j % 2 == 1) ? (d == dwe - 1) : (d == 0)) begin
                        corr_valid = 1'b1;
                        corr_mag   = 16'(pk[j]);
                    end else begin
                        corr_valid = 1'($urandom_range(0, 1));
                        corr_mag   = 16'($urandom_range(0, pk[j]));
                    end
                end else begin
                    corr_valid = 1'b0;
                    corr_mag   = 16'h0;
                end
                @(posedge clk); #1;
                if (done === 1'b1) begin
                    done_o = cyc - m_s;
                    hit    = 1'b1;
                end
            end
        end
        corr_valid = 1'b0;
        corr_mag   = '0;
        if (!hit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sweep_timeout: got no done within %0d cycles", m_per * nse + 4);
        end
    endtask

    initial begin
        int dn;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_nco_rst", 32'(nco_rst), 1);
        check("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        pk = '{10, 50, 30, 20, 0, 0, 0, 0};
        run_sweep('h100, 'h010, 'h055, 4, 8, 40, -1, 0, dn);
        check("A_done_at", dn, 52);
        check("A_best_word", 32'(best_word), 'h110);
        check("A_best_mag", 32'(best_mag), 50);
        check("A_locked", 32'(locked), 1);
        check("A_ctrl_word", 32'(control_word), 'h110);
        repeat (3) @(posedge clk);
        #1;

        run_sweep('h100, 'h010, 'h055, 4, 8, 60, -1, 0, dn);
        check("B_done_at", dn, 52);
        check("B_locked", 32'(locked), 0);
        check("B_ctrl_word", 32'(control_word), 0);
        check("B_best_mag", 32'(best_mag), 50);

        pk = '{50, 50, 0, 0, 0, 0, 0, 0};
        run_sweep('h0AB, 'h011, 'h123, 2, 5, 0, -1, 0, dn);
        check("C_tie_word", 32'(best_word), 'h0AB);

        pk = '{5, 9, 0, 0, 0, 0, 0, 0};
        run_sweep('h1FF0, 'h020, 'h001, 2, 3, 9, -1, 0, dn);
        check("D_wrap_word", 32'(best_word), 'h0010);
        check("D_locked", 32'(locked), 1);

        pk = '{10, 50, 30, 20, 0, 0, 0, 0};
        run_sweep('h100, 'h010, 'h055, 4, 8, 40, 19, 1, dn);
        check("E_abort_busy", 32'(busy), 0);
        check("E_abort_done", 32'(done), 0);
        check("E_abort_mag", 32'(best_mag), 10);
        repeat (3) @(posedge clk);
        #1;

        pk = '{7, 0, 0, 0, 0, 0, 0, 0};
        run_sweep('h0AA, 'h005, 'h0FF, 0, 0, 7, -1, 0, dn);
        check("F_done_at", dn, 6);
        check("F_locked", 32'(locked), 1);
        check("F_best_mag", 32'(best_mag), 7);

        pk = '{3, 4, 5, 0, 0, 0, 0, 0};
        run_sweep('h200, 'h040, 'h010, 3, 4, 1, 10, 2, dn);
        check("G_rst_mag", 32'(best_mag), 0);
        repeat (3) @(posedge clk);
        #1;

        for (int k = 0; k < 8; k++) pk[k] = $urandom_range(0, 1000);
        run_sweep($urandom_range(0, 8191), $urandom_range(0, 8191), 'h0777,
                  5, 3, 500, -1, 0, dn);
        check("H_done_at", dn, 5 * (ST + 3 + 1));
        repeat (4) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 4, cycles ignored after each NCO word change (covers NCO input latch plus output pipeline).
REQ-002 SHALL have parameter W, default 13, NCO word width.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  sole clock, all logic on rising edge; rst  in  1  synchronous active-high reset.
REQ-004 start  in  1  sweep request, sampled only in IDLE and TRACK.
REQ-005 abort  in  1  forces IDLE next cycle; wins over start.
REQ-006 f_min  in  W  first frequency word; f_step  in  W  per-step increment.
REQ-007 n_steps  in  8  frequency points (0 treated as 1); dwell  in  16  cycles per point (0 treated as 1).
REQ-008 phase_offset  in  W  phase word; lock_thresh  in  16  minimum peak for lock.
REQ-009 corr_valid  in  1  correlator sample strobe; corr_mag  in  16  unsigned correlator magnitude.
REQ-010 control_word  out  W  to NCO frequency input; phase_control_word  out  W  to NCO phase input; nco_rst  out  1  NCO accumulator reset.
REQ-011 busy  out  1  sweep in progress; done  out  1  one-cycle completion pulse; locked  out  1  lock level; best_word  out  W  winning word; best_mag  out  16  winning peak.

Function
REQ-012 States SHALL be IDLE, SETTLE, DWELL, EVAL, TRACK; busy = 1 exactly in SETTLE, DWELL and EVAL.
REQ-013 start in IDLE/TRACK SHALL latch all config inputs, set control_word=f_min, phase_control_word=phase_offset, step_idx=0, best_mag=0, best_word=f_min, locked=0, then enter SETTLE.
REQ-014 nco_rst SHALL be 1 only in the first SETTLE cycle of step 0.
REQ-015 SETTLE SHALL last exactly SETTLE cycles, ignore corr_valid, then enter DWELL with peak=0 and dwell counter loaded.
REQ-016 DWELL SHALL last exactly max(dwell,1) cycles; on each corr_valid, peak <= max(peak, corr_mag); a sample on the last DWELL cycle counts.
REQ-017 EVAL (1 cycle) SHALL update best_mag/best_word only if peak > best_mag (strict; ties keep earlier step).
REQ-018 EVAL with steps remaining SHALL add f_step to control_word modulo 2^W (wrap allowed), increment step_idx, enter SETTLE.
REQ-019 EVAL on step max(n_steps,1)-1 SHALL pulse done, enter TRACK, set control_word=best_word, and set locked=1 iff final best_mag >= lock_thresh, else control_word=0.
REQ-020 TRACK SHALL hold all outputs until start or abort.
REQ-021 abort SHALL, from any state, zero control_word, phase_control_word, locked, busy, done and enter IDLE; best_word/best_mag hold.
REQ-022 Config inputs changing mid-sweep SHALL have no effect.

Reset
REQ-023 rst SHALL force IDLE; control_word, phase_control_word, best_word, best_mag, busy, done, locked = 0; nco_rst = 1 during rst, 0 after.
REQ-024 rst mid-sweep SHALL abandon the sweep with no done pulse.

Structure
REQ-025 State enum, W and SETTLE default SHALL live in shared package nco_ctrl_pkg.
REQ-026 The block SHALL be purely controller logic with no submodule; the NCO is instantiated by the parent.

Verification
REQ-027 f_min=0x100, f_step=0x010, n_steps=4, dwell=8; peaks 10,50,30,20, thresh=40 -> control_word 0x100,0x110,0x120,0x130; done after 4x(4+8+1)=52 cycles from start; best_word=0x110, best_mag=50, locked=1.
REQ-028 Same sweep with thresh=60 -> done pulse, locked=0, control_word=0, best_mag=50.
REQ-029 Equal peaks 50,50 over n_steps=2 -> best_word=f_min (tie keeps first).
REQ-030 f_min=0x1FF0, f_step=0x20, n_steps=2 -> second word 0x0010 (wrap).
REQ-031 abort and start in same DWELL cycle -> IDLE next cycle, busy=0, no done; n_steps=0, dwell=0 -> one step, done 6 cycles after start.
